// File: rtl/sprite_scanline_renderer_pkg.sv
// Shared definitions for the sprite scanline renderer: FSM state type and
// the width of the visible region of a scanline.
package sprite_scanline_renderer_pkg;

  localparam int unsigned H_DISPLAY = 256;

  typedef enum logic [2:0] {
    WAIT_VSTART = 3'd0,
    WAIT_LOAD   = 3'd1,
    LOAD_SETUP  = 3'd2,
    LOAD_FETCH  = 3'd3,
    WAIT_HSTART = 3'd4,
    DRAW        = 3'd5
  } state_e;

endpackage

// File: rtl/sprite_scanline_renderer.sv
// Single-sprite scanline renderer. Fetches one bitmap row per line from an
// external synchronous ROM during hblank and serialises it onto gfx, one
// cycle behind hpos to line up with the timing generator's registered
// display_on. gfx is not masked here; the colour mixer does that.
module sprite_scanline_renderer
  import sprite_scanline_renderer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 16,
  parameter int ABITS     = 4,
  parameter int LOAD_HPOS = 270
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  input  logic [8:0]       sprite_x,
  input  logic [8:0]       sprite_y,
  output logic [ABITS-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_bits,
  output logic             gfx,
  output logic             in_progress
);

  localparam int XBITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [8:0]       LOAD_H = 9'(LOAD_HPOS);
  localparam logic [8:0]       H_DISP = 9'(H_DISPLAY);
  localparam logic [ABITS-1:0] YLAST  = ABITS'(HEIGHT - 1);
  localparam logic [XBITS-1:0] XLAST  = XBITS'(WIDTH - 1);

  state_e             state_q;
  logic [ABITS-1:0]   ycount_q;
  logic [XBITS-1:0]   xcount_q;
  logic [WIDTH-1:0]   rowbits_q;
  logic [8:0]         xlatch_q;
  logic [ABITS-1:0]   rom_addr_q;
  logic               gfx_q;
  logic               in_progress_q;

  logic [XBITS-1:0]   pix_idx;

  // Bit position in the latched row of the pixel emitted this cycle.
  always_comb begin
    pix_idx = XLAST - xcount_q;
  end

  // Sprite FSM with registered ROM address, pixel and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_VSTART;
      ycount_q      <= '0;
      xcount_q      <= '0;
      rowbits_q     <= '0;
      xlatch_q      <= '0;
      rom_addr_q    <= '0;
      gfx_q         <= 1'b0;
      in_progress_q <= 1'b0;
    end else begin
      gfx_q <= 1'b0;
      case (state_q)
        WAIT_VSTART: begin
          if (hpos == '0 && vpos == sprite_y) begin
            state_q       <= WAIT_LOAD;
            ycount_q      <= '0;
            in_progress_q <= 1'b1;
          end
        end
        WAIT_LOAD: begin
          if (hpos == LOAD_H) begin
            state_q    <= LOAD_SETUP;
            rom_addr_q <= ycount_q;
          end
        end
        LOAD_SETUP: begin
          state_q <= LOAD_FETCH;
        end
        LOAD_FETCH: begin
          rowbits_q <= rom_bits;
          xlatch_q  <= sprite_x;
          state_q   <= WAIT_HSTART;
        end
        WAIT_HSTART: begin
          if (hpos == xlatch_q && xlatch_q < H_DISP) begin
            // Pixel 0 is registered on the entry edge so that pixel k is
            // visible while hpos == xlatch+1+k; DRAW then covers pixels 1..WIDTH-1.
            state_q  <= DRAW;
            gfx_q    <= rowbits_q[WIDTH-1];
            xcount_q <= XBITS'(1);
          end else if (hpos == LOAD_H) begin
            if (ycount_q == YLAST) begin
              state_q       <= WAIT_VSTART;
              in_progress_q <= 1'b0;
            end else begin
              ycount_q   <= ycount_q + 1'b1;
              rom_addr_q <= ycount_q + 1'b1;
              state_q    <= LOAD_SETUP;
            end
          end
        end
        DRAW: begin
          gfx_q    <= rowbits_q[pix_idx];
          xcount_q <= xcount_q + 1'b1;
          if (xcount_q == XLAST) begin
            if (ycount_q == YLAST) begin
              state_q       <= WAIT_VSTART;
              in_progress_q <= 1'b0;
            end else begin
              ycount_q <= ycount_q + 1'b1;
              state_q  <= WAIT_LOAD;
            end
          end
        end
        default: begin
          state_q       <= WAIT_VSTART;
          in_progress_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign gfx         = gfx_q;
  assign in_progress = in_progress_q;

endmodule
